// File: rtl/integ_pkg.sv
// Shared integrator definitions: accumulator/counter widths and the
// window-result entry layout stored in the result FIFO.
package integ_pkg;

    localparam int unsigned SUM_W = 13;
    localparam int unsigned CNT_W = 5;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [SUM_W-1:0] sum;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage : integ_pkg

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with level tracking.
// When empty, the read data holds the most recently popped entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [AW-1:0]    w_last_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full_c   = (r_level == LW'(DEPTH));
    assign o_empty_c  = (r_level == '0);
    assign o_level    = r_level;
    assign w_pop      = i_pop & ~o_empty_c;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push     = i_push & (~o_full_c | w_pop);
    assign w_last_ptr = r_rd_ptr - AW'(1);
    assign o_rdata_c  = o_empty_c ? r_mem[w_last_ptr] : r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/integrator_result_fifo.sv
// Captures each accumulation window's final sum and sample count and
// buffers them for a valid/ready consumer, flagging dropped windows.
module integrator_result_fifo
    import integ_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             acc_en,
    input  logic [SUM_W-1:0] acc_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic [LW-1:0]    level,
    output logic             overflow,
    input  logic             clr_ovf
);

    logic               r_en_q;
    logic [CNT_W-1:0]   r_run_cnt;
    logic               r_overflow;
    logic               w_win_end;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_ovf_set;
    entry_t             w_wr_entry;
    entry_t             w_rd_entry;
    logic [ENTRY_W-1:0] w_rd_data;

    assign w_win_end  = r_en_q & ~acc_en;
    assign out_valid  = ~w_empty;
    assign w_pop      = out_valid & out_ready;
    assign w_ovf_set  = w_win_end & w_full & ~w_pop;
    assign w_wr_entry = '{cnt: r_run_cnt, sum: acc_y};
    assign w_rd_entry = entry_t'(w_rd_data);
    assign out_sum    = w_rd_entry.sum;
    assign out_cnt    = w_rd_entry.cnt;
    assign overflow   = r_overflow;

    // Window tracking: sample counter saturates, cleared at window end.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_en_q     <= 1'b0;
            r_run_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_en_q <= acc_en;
            if (acc_en) begin
                r_run_cnt <= (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + CNT_W'(1);
            end else if (w_win_end) begin
                r_run_cnt <= '0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_win_end),
        .i_wdata   (w_wr_entry),
        .i_pop     (w_pop),
        .o_rdata_c (w_rd_data),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_level   (level)
    );

endmodule : integrator_result_fifo

// File: tb/tb_integrator_result_fifo.sv
// Directed self-checking bench for integrator_result_fifo.
module tb_integrator_result_fifo;

    logic        clock;
    logic        reset;
    logic        acc_en;
    logic [12:0] acc_y;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_sum;
    logic [4:0]  out_cnt;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;

    int n_assert;
    int n_fail;

    integrator_result_fifo #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .acc_en    (acc_en),
        .acc_y     (acc_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // acc_en high for n posedges with constant acc_y, then one win_end posedge.
    task automatic window(input int n, input logic [12:0] y);
        acc_en = 1'b1;
        acc_y  = y;
        repeat (n) tick();
        acc_en = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [12:0] exp_sums [4];
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        acc_en    = 1'b0;
        acc_y     = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        reset = 1'b1;

        // 1: normal window
        acc_en = 1'b1;
        acc_y = 13'd250;  tick();
        acc_y = 13'd500;  tick();
        acc_y = 13'd750;  tick();
        acc_y = 13'd1000; tick();
        acc_en = 1'b0;
        chk("t1_valid_pre", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'h3E8);
        chk("t1_cnt", 32'(out_cnt), 32'd4);
        chk("t1_level", 32'(level), 32'd1);
        pop_one();
        chk("t1_valid_pop", 32'(out_valid), 32'd0);
        chk("t1_level_pop", 32'(level), 32'd0);
        chk("t1_sum_hold", 32'(out_sum), 32'h3E8);
        chk("t1_cnt_hold", 32'(out_cnt), 32'd4);

        // 2: fill and overflow; clear asserted during the dropping win_end
        window(1, 13'd100);
        window(1, 13'd200);
        window(1, 13'd300);
        window(1, 13'd400);
        chk("t2_level4", 32'(level), 32'd4);
        chk("t2_ovf_pre", 32'(overflow), 32'd0);
        clr_ovf = 1'b1;
        window(1, 13'd500);
        clr_ovf = 1'b0;
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_ovf_set_wins", 32'(overflow), 32'd1);
        chk("t2_head_sum", 32'(out_sum), 32'd100);
        chk("t2_head_cnt", 32'(out_cnt), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: full with simultaneous pop at win_end
        acc_en = 1'b1;
        acc_y  = 13'd600;
        tick();
        acc_en    = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_level", 32'(level), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd0);
        exp_sums[0] = 13'd200;
        exp_sums[1] = 13'd300;
        exp_sums[2] = 13'd400;
        exp_sums[3] = 13'd600;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order_%0d", i), 32'(out_sum), 32'(exp_sums[i]));
            pop_one();
        end
        chk("t3_drained", 32'(level), 32'd0);

        // 4: counter saturation
        window(40, 13'h1ABC);
        chk("t4_cnt_sat", 32'(out_cnt), 32'd31);
        chk("t4_sum", 32'(out_sum), 32'h1ABC);
        chk("t4_level", 32'(level), 32'd1);
        pop_one();

        // 5: reset mid-window, acc_en held high across reset release
        acc_en = 1'b1;
        acc_y  = 13'd9;
        repeat (3) tick();
        reset = 1'b0;
        acc_y = 13'd77;
        #1;
        chk("t5_rst_level", 32'(level), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_sum", 32'(out_sum), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        acc_en = 1'b0;
        chk("t5_no_abort_entry", 32'(level), 32'd0);
        tick();
        chk("t5_level", 32'(level), 32'd1);
        chk("t5_cnt", 32'(out_cnt), 32'd2);
        chk("t5_sum", 32'(out_sum), 32'd77);
        pop_one();
        chk("t5_empty", 32'(level), 32'd0);

        // 6: back-to-back windows, acc_en 1,1,0,1,0
        acc_en = 1'b1; acc_y = 13'h005; tick();
        acc_en = 1'b1; acc_y = 13'h00A; tick();
        acc_en = 1'b0; acc_y = 13'h0AA; tick();
        acc_en = 1'b1; acc_y = 13'h003; tick();
        acc_en = 1'b0; acc_y = 13'h155; tick();
        chk("t6_level", 32'(level), 32'd2);
        chk("t6_cnt0", 32'(out_cnt), 32'd2);
        chk("t6_sum0", 32'(out_sum), 32'h0AA);
        pop_one();
        chk("t6_cnt1", 32'(out_cnt), 32'd1);
        chk("t6_sum1", 32'(out_sum), 32'h155);
        pop_one();
        chk("t6_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_integrator_result_fifo
